// File: rtl/fmap_pingpong_buffer_pkg.sv
// Shared defaults for the pooled feature-map ping-pong store.
// Pixel width is derived so every block agrees on the CH*DW packing.
package fmap_pingpong_buffer_pkg;
    localparam int CH_DEF        = 64;
    localparam int DW_DEF        = 16;
    localparam int FRAME_PIX_DEF = 3025;
    localparam int AW_DEF        = 12;
    localparam int PIX_W_DEF     = CH_DEF * DW_DEF;
endpackage

// File: rtl/fmap_pingpong_buffer_if.sv
// Write-side and read-side handshake bundle of the ping-pong store.
// The slave modport is the buffer; master is the producer/consumer side.
interface fmap_pingpong_buffer_if
    import fmap_pingpong_buffer_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
);
    logic             i_data_valid;
    logic [PIX_W-1:0] i_data;
    logic             o_in_ready;
    logic [PIX_W-1:0] o_data;
    logic             o_data_valid;
    logic             i_out_ready;
    logic             o_frame_last;
    logic [1:0]       o_bank_full;
    logic             o_overflow;

    modport slave (
        input  i_data_valid, i_data, i_out_ready,
        output o_in_ready, o_data, o_data_valid, o_frame_last, o_bank_full, o_overflow
    );
    modport master (
        output i_data_valid, i_data, i_out_ready,
        input  o_in_ready, o_data, o_data_valid, o_frame_last, o_bank_full, o_overflow
    );
endinterface

// File: rtl/fmap_pingpong_buffer_bank_ram.sv
// Two-bank 1W/1R RAM addressed as {bank, addr}; the read register is the
// pixel output and only advances on a read enable, so stalls hold it.
module fmap_bank_ram
    import fmap_pingpong_buffer_pkg::*;
#(
    parameter int FRAME_PIX = FRAME_PIX_DEF,
    parameter int AW        = AW_DEF,
    parameter int W         = PIX_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [AW:0]  waddr,
    input  logic [W-1:0] wdata,
    input  logic         re,
    input  logic [AW:0]  raddr,
    output logic [W-1:0] rdata
);
    localparam int DEPTH = 2 * FRAME_PIX;
    localparam int IW    = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  rdata_d, rdata_q;
    logic [IW-1:0] widx, ridx;

    // Banks are packed back to back so depth stays 2*FRAME_PIX, not 2^(AW+1).
    function automatic int lin(input logic [AW:0] a);
        return (a[AW] ? FRAME_PIX : 0) + int'(a[AW-1:0]);
    endfunction

    assign widx = IW'(lin(waddr));
    assign ridx = IW'(lin(raddr));

    always_ff @(posedge clk) begin
        if (we) mem[widx] <= wdata;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem[ridx];
    end

    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else     rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/fmap_pingpong_buffer.sv
// Ping-pong frame store: one bank fills from maxpool while the other streams
// to the squeeze stage; a bank is freed when its last pixel is handed off.
module fmap_pingpong_buffer
    import fmap_pingpong_buffer_pkg::*;
#(
    parameter int CH        = CH_DEF,
    parameter int DW        = DW_DEF,
    parameter int FRAME_PIX = FRAME_PIX_DEF,
    parameter int AW        = AW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    fmap_pingpong_buffer_if.slave bus
);
    localparam int            PIX_W = CH * DW;
    localparam logic [AW-1:0] LAST  = AW'(FRAME_PIX - 1);

    logic          wbank_q, wbank_d, ibank_q, ibank_d, tag_q, tag_d;
    logic [AW-1:0] waddr_q, waddr_d, iaddr_q, iaddr_d;
    logic [1:0]    full_q, full_d;
    logic          vld_q, vld_d, last_q, last_d, ovf_q, ovf_d;
    logic          wr, en, issue, rel;

    always_comb begin
        wr    = bus.i_data_valid && !full_q[wbank_q];
        en    = !vld_q || bus.i_out_ready;
        // A bank whose final pixel is still on the output must not be re-issued.
        issue = en && full_q[ibank_q] && !(ibank_q == tag_q && vld_q && last_q);
        rel   = vld_q && bus.i_out_ready && last_q;

        wbank_d = wbank_q;
        waddr_d = waddr_q;
        ibank_d = ibank_q;
        iaddr_d = iaddr_q;
        tag_d   = tag_q;
        full_d  = full_q;
        vld_d   = vld_q;
        last_d  = last_q;
        ovf_d   = ovf_q | (bus.i_data_valid && full_q[wbank_q]);

        if (wr) begin
            if (waddr_q == LAST) begin
                waddr_d         = '0;
                wbank_d         = !wbank_q;
                full_d[wbank_q] = 1'b1;
            end else begin
                waddr_d = waddr_q + AW'(1);
            end
        end
        if (rel) full_d[tag_q] = 1'b0;

        if (issue) begin
            vld_d  = 1'b1;
            last_d = (iaddr_q == LAST);
            tag_d  = ibank_q;
            if (iaddr_q == LAST) begin
                iaddr_d = '0;
                ibank_d = !ibank_q;
            end else begin
                iaddr_d = iaddr_q + AW'(1);
            end
        end else if (en) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbank_q <= 1'b0;
            waddr_q <= '0;
            ibank_q <= 1'b0;
            iaddr_q <= '0;
            tag_q   <= 1'b0;
            full_q  <= 2'b00;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbank_q <= wbank_d;
            waddr_q <= waddr_d;
            ibank_q <= ibank_d;
            iaddr_q <= iaddr_d;
            tag_q   <= tag_d;
            full_q  <= full_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

    fmap_bank_ram #(
        .FRAME_PIX (FRAME_PIX),
        .AW        (AW),
        .W         (PIX_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr),
        .waddr ({wbank_q, waddr_q}),
        .wdata (bus.i_data),
        .re    (issue),
        .raddr ({ibank_q, iaddr_q}),
        .rdata (bus.o_data)
    );

    assign bus.o_in_ready   = !full_q[wbank_q];
    assign bus.o_data_valid = vld_q;
    assign bus.o_frame_last = last_q;
    assign bus.o_bank_full  = full_q;
    assign bus.o_overflow   = ovf_q;
endmodule
